// File: rtl/mips_memsys.sv
// mips_memsys: memory port target for the multicycle MIPS core.
// Word-addressed RAM with combinational read, plus a small MMIO block
// holding a TX FIFO (drained by a valid/ready sink), a free-running cycle
// counter and a sticky error register. Bit 31 of the address splits the
// two regions; the two lowest address bits are ignored everywhere.
module mips_memsys #(
    parameter int WIDTH     = 32,
    parameter int ADDRBITS  = 8,
    parameter int FIFODEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread,
    input  logic             memwrite,
    input  logic [WIDTH-1:0] adr,
    input  logic [WIDTH-1:0] writedata,
    output logic [WIDTH-1:0] memdata,
    output logic [WIDTH-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    localparam int PTRW     = $clog2(FIFODEPTH);
    localparam int CNTW     = PTRW + 1;
    localparam int RAMWORDS = 1 << ADDRBITS;

    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CYCLE  = 2'd2;
    localparam logic [1:0] REG_ERR    = 2'd3;

    // storage
    logic [WIDTH-1:0] ram      [0:RAMWORDS-1];
    logic [WIDTH-1:0] fifo_mem [0:FIFODEPTH-1];

    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [CNTW-1:0]  count;
    logic [31:0]      cycle_cnt;
    logic             err_ovf;

    // address decode
    logic                sel_mmio;
    logic [ADDRBITS-1:0] ram_idx;
    logic [1:0]          reg_idx;

    // write strobes; MMIO writes are suppressed while reset is asserted,
    // RAM writes are not (RAM has no reset and keeps its contents)
    logic wr_ram;
    logic wr_mmio;
    logic wr_txdata;
    logic wr_cycle;
    logic wr_err;

    // FIFO control
    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic overflow;

    logic [31:0] status_word;
    logic [31:0] mmio_rdata;

    // Address bits outside the decoded fields alias by design.
    logic unused_bits;
    assign unused_bits = ^{adr, writedata};

    assign sel_mmio = adr[31];
    assign ram_idx  = adr[ADDRBITS+1:2];
    assign reg_idx  = adr[3:2];

    assign wr_ram    = memwrite & ~sel_mmio;
    assign wr_mmio   = memwrite & sel_mmio & ~reset;
    assign wr_txdata = wr_mmio & (reg_idx == REG_TXDATA);
    assign wr_cycle  = wr_mmio & (reg_idx == REG_CYCLE);
    assign wr_err    = wr_mmio & (reg_idx == REG_ERR);

    // Full/empty come from pre-edge state: a push while full is dropped
    // even if the sink pops in the same cycle.
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNTW'(FIFODEPTH));
    assign push       = wr_txdata & ~fifo_full;
    assign overflow   = wr_txdata & fifo_full;
    assign pop        = ~fifo_empty & tx_ready;

    // Head is driven straight from storage; the slot under rd_ptr is never
    // written while occupied, so tx_data holds while the sink stalls.
    assign tx_valid = ~fifo_empty;
    assign tx_data  = fifo_empty ? '0 : fifo_mem[rd_ptr];

    // RAM write port
    always_ff @(posedge clk) begin
        if (wr_ram) begin
            ram[ram_idx] <= writedata;
        end
    end

    // FIFO storage write; entries are not reset, validity comes from count
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= writedata;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Free-running cycle counter; a software write replaces the increment
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
        end else if (wr_cycle) begin
            cycle_cnt <= writedata[31:0];
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    // Sticky overflow flag; a fresh overflow beats a same-cycle clear
    always_ff @(posedge clk) begin
        if (reset) begin
            err_ovf <= 1'b0;
        end else if (overflow) begin
            err_ovf <= 1'b1;
        end else if (wr_err && writedata[0]) begin
            err_ovf <= 1'b0;
        end
    end

    assign status_word = {16'd0, 8'(count), 6'd0, fifo_full, fifo_empty};

    // MMIO read mux
    always_comb begin
        mmio_rdata = 32'd0;
        case (reg_idx)
            REG_TXDATA: mmio_rdata = 32'd0;
            REG_STATUS: mmio_rdata = status_word;
            REG_CYCLE:  mmio_rdata = cycle_cnt;
            REG_ERR:    mmio_rdata = {31'd0, err_ovf};
            default:    mmio_rdata = 32'd0;
        endcase
    end

    // Read data to the core: zero unless memread, pre-edge contents otherwise
    always_comb begin
        memdata = '0;
        if (memread) begin
            if (sel_mmio) begin
                memdata = WIDTH'(mmio_rdata);
            end else begin
                memdata = ram[ram_idx];
            end
        end
    end

endmodule

// File: tb/tb_mips_memsys.sv
// tb_mips_memsys: directed vectors plus hand-written multi-cycle sequences
// for the FIFO, overflow, cycle counter and reset behaviour.
module tb_mips_memsys;

    localparam logic [31:0] A_TX   = 32'h8000_0000;
    localparam logic [31:0] A_STAT = 32'h8000_0004;
    localparam logic [31:0] A_CYC  = 32'h8000_0008;
    localparam logic [31:0] A_ERR  = 32'h8000_000C;

    logic        clk;
    logic        reset;
    logic        memread;
    logic        memwrite;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic [31:0] memdata;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic        rdy;
        logic [31:0] exp_md;
        logic        exp_v;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vecs [17];

    mips_memsys #(.WIDTH(32), .ADDRBITS(8), .FIFODEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .memread   (memread),
        .memwrite  (memwrite),
        .adr       (adr),
        .writedata (writedata),
        .memdata   (memdata),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic rdy);
        memread   = rd;
        memwrite  = wr;
        adr       = a;
        writedata = wd;
        tx_ready  = rdy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // RAM, basic FIFO and STATUS behaviour, one vector per cycle
        vecs[0]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b1, 1'b0, 32'h10,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[2]  = '{1'b1, 1'b0, 32'h13,   32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[3]  = '{1'b0, 1'b0, 32'h10,   32'h0,        1'b0, 32'h0,        1'b0, 32'h0};
        vecs[4]  = '{1'b1, 1'b1, 32'h10,   32'h11111111, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0};
        vecs[5]  = '{1'b1, 1'b0, 32'h410,  32'h0,        1'b0, 32'h11111111, 1'b0, 32'h0};
        vecs[6]  = '{1'b0, 1'b1, A_TX,     32'h41,       1'b0, 32'h0,        1'b0, 32'h0};
        vecs[7]  = '{1'b0, 1'b1, A_TX,     32'h42,       1'b0, 32'h0,        1'b1, 32'h41};
        vecs[8]  = '{1'b0, 1'b1, A_TX,     32'h43,       1'b0, 32'h0,        1'b1, 32'h41};
        vecs[9]  = '{1'b1, 1'b0, A_STAT,   32'h0,        1'b0, 32'h300,      1'b1, 32'h41};
        vecs[10] = '{1'b1, 1'b0, A_TX,     32'h0,        1'b0, 32'h0,        1'b1, 32'h41};
        vecs[11] = '{1'b1, 1'b0, A_STAT,   32'h0,        1'b1, 32'h300,      1'b1, 32'h41};
        vecs[12] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        1'b1, 32'h42};
        vecs[13] = '{1'b0, 1'b0, 32'h0,    32'h0,        1'b1, 32'h0,        1'b1, 32'h43};
        vecs[14] = '{1'b1, 1'b0, A_STAT,   32'h0,        1'b1, 32'h1,        1'b0, 32'h0};
        vecs[15] = '{1'b1, 1'b1, A_STAT,   32'hFFFFFFFF, 1'b0, 32'h1,        1'b0, 32'h0};
        vecs[16] = '{1'b1, 1'b0, A_STAT,   32'h0,        1'b0, 32'h1,        1'b0, 32'h0};

        // reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        tick;
        tick;
        #2;
        chk("rst_memdata", memdata, 32'h0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        chk("rst_tx_data", tx_data, 32'h0);
        tick;
        reset = 1'b0;
        drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
        #2 chk("cycle_after_reset", memdata, 32'h0);
        tick;
        #2 chk("cycle_plus1", memdata, 32'h1);
        tick;
        drive(1'b1, 1'b0, A_ERR, 32'h0, 1'b0);
        #2 chk("rst_err", memdata, 32'h0);
        tick;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 1'b0);
        #2 chk("rst_status", memdata, 32'h1);
        tick;

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            drive(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, vecs[i].rdy);
            #2;
            chk($sformatf("vec%0d_memdata", i), memdata, vecs[i].exp_md);
            chk($sformatf("vec%0d_tx_valid", i), {31'd0, tx_valid}, {31'd0, vecs[i].exp_v});
            chk($sformatf("vec%0d_tx_data", i), tx_data, vecs[i].exp_d);
            tick;
        end

        // overflow: nine pushes into an eight-deep FIFO
        for (int i = 1; i <= 9; i++) begin
            drive(1'b0, 1'b1, A_TX, i, 1'b0);
            tick;
        end
        drive(1'b1, 1'b0, A_STAT, 32'h0, 1'b0);
        #2 chk("ovf_status", memdata, 32'h802);
        tick;
        drive(1'b1, 1'b0, A_ERR, 32'h0, 1'b0);
        #2 chk("ovf_err", memdata, 32'h1);
        tick;
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #2;
            chk($sformatf("ovf_drain%0d_valid", i), {31'd0, tx_valid}, 32'h1);
            chk($sformatf("ovf_drain%0d_data", i), tx_data, i);
            tick;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #2 chk("ovf_drained_valid", {31'd0, tx_valid}, 32'h0);
        tick;
        drive(1'b0, 1'b1, A_ERR, 32'h1, 1'b0);
        tick;
        drive(1'b1, 1'b0, A_ERR, 32'h0, 1'b0);
        #2 chk("ovf_err_cleared", memdata, 32'h0);
        tick;

        // full FIFO with simultaneous pop and push
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, A_TX, 32'h10 + i, 1'b0);
            tick;
        end
        drive(1'b1, 1'b1, A_TX, 32'h99, 1'b1);
        #2;
        chk("fullpp_head", tx_data, 32'h10);
        chk("fullpp_txdata_read", memdata, 32'h0);
        tick;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 1'b0);
        #2 chk("fullpp_status", memdata, 32'h700);
        tick;
        drive(1'b1, 1'b0, A_ERR, 32'h0, 1'b0);
        #2 chk("fullpp_err", memdata, 32'h1);
        tick;
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            #2;
            chk($sformatf("fullpp_drain%0d_valid", i), {31'd0, tx_valid}, 32'h1);
            chk($sformatf("fullpp_drain%0d_data", i), tx_data, 32'h11 + i);
            tick;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        #2 chk("fullpp_no_99", {31'd0, tx_valid}, 32'h0);
        tick;
        drive(1'b0, 1'b1, A_ERR, 32'h1, 1'b0);
        tick;

        // cycle counter load and wrap
        drive(1'b0, 1'b1, A_CYC, 32'hFFFFFFFE, 1'b0);
        tick;
        drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
        #2 chk("cyc_load", memdata, 32'hFFFFFFFE);
        tick;
        #2 chk("cyc_max", memdata, 32'hFFFFFFFF);
        tick;
        #2 chk("cyc_wrap", memdata, 32'h0);
        tick;

        // reset in the middle of a drain, with ERR set and a TX write pending
        for (int i = 0; i < 9; i++) begin
            drive(1'b0, 1'b1, A_TX, 32'h20 + i, 1'b0);
            tick;
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
            tick;
        end
        reset = 1'b1;
        drive(1'b0, 1'b1, A_TX, 32'h77, 1'b1);
        tick;
        reset = 1'b0;
        drive(1'b1, 1'b0, A_CYC, 32'h0, 1'b0);
        #2;
        chk("mid_rst_cycle", memdata, 32'h0);
        chk("mid_rst_valid", {31'd0, tx_valid}, 32'h0);
        chk("mid_rst_data", tx_data, 32'h0);
        tick;
        drive(1'b1, 1'b0, A_STAT, 32'h0, 1'b0);
        #2 chk("mid_rst_status", memdata, 32'h1);
        tick;
        drive(1'b1, 1'b0, A_ERR, 32'h0, 1'b0);
        #2 chk("mid_rst_err", memdata, 32'h0);
        tick;
        drive(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        #2 chk("mid_rst_ram_kept", memdata, 32'h11111111);
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
